// File: rtl/matmul_scheduler.sv
// Sequencer for the matrix-multiply datapath: loads A/B operand rows, runs the
// systolic array, writes result rows to a scratchpad and gathers overflow flags.
module matmul_scheduler #(
    parameter  int BUS_WIDTH   = 32,
    parameter  int DATA_WIDTH  = 8,
    parameter  int SP_NTARGETS = 4,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int IDXW        = $clog2(MAX_DIM),
    localparam int TW          = $clog2(SP_NTARGETS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [IDXW-1:0]              n_dim_i,
    input  logic [IDXW-1:0]              k_dim_i,
    input  logic [IDXW-1:0]              m_dim_i,
    input  logic [TW-1:0]                target_i,
    input  logic [MAX_DIM-1:0]           ovf_i,
    output logic                         busy_o,
    output logic                         rd_en_o,
    output logic                         rd_sel_o,
    output logic [IDXW-1:0]              rd_row_o,
    output logic                         load_a_o,
    output logic                         load_b_o,
    output logic                         pe_clr_o,
    output logic                         pe_en_o,
    output logic                         wr_en_o,
    output logic [TW-1:0]                wr_target_o,
    output logic [IDXW-1:0]              wr_row_o,
    output logic [MAX_DIM*MAX_DIM-1:0]   flags_o,
    output logic                         done_o,
    output logic                         start_err_o
);
    // Longest phase (COMPUTE) counts up to 3*(MAX_DIM-1); one spare value avoids wrap.
    localparam int CW = $clog2(3 * (MAX_DIM - 1) + 2);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITEBACK, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [IDXW-1:0]              n_q, n_d, k_q, k_d, m_q, m_d;
    logic [TW-1:0]                tgt_q, tgt_d;
    logic [CW-1:0]                ne_q, ke_q, me_q, ne_d, ke_d;
    logic                         accept;

    logic                         busy_q, busy_d, rd_en_q, rd_en_d, rd_sel_q, rd_sel_d;
    logic [IDXW-1:0]              rd_row_q, rd_row_d, wr_row_q, wr_row_d;
    logic                         load_a_q, load_a_d, load_b_q, load_b_d;
    logic                         pe_clr_q, pe_clr_d, pe_en_q, pe_en_d, wr_en_q, wr_en_d;
    logic [TW-1:0]                wr_target_q, wr_target_d;
    logic [MAX_DIM*MAX_DIM-1:0]   flags_q, flags_d, flag_set;
    logic                         done_q, done_d, start_err_q, start_err_d;

    assign ne_q = CW'(n_q);
    assign ke_q = CW'(k_q);
    assign me_q = CW'(m_q);

    // Overflow for element (row, col) is captured while that row is on the write port.
    for (genvar gi = 0; gi < MAX_DIM * MAX_DIM; gi++) begin : g_flag
        assign flag_set[gi] = wr_en_q && (wr_row_q == IDXW'(gi / MAX_DIM))
                              && ((gi % MAX_DIM) <= int'(m_q)) && ovf_i[gi % MAX_DIM];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        n_d         = n_q;
        k_d         = k_q;
        m_d         = m_q;
        tgt_d       = tgt_q;
        accept      = 1'b0;
        start_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                    cnt_d   = '0;
                    n_d     = n_dim_i;
                    k_d     = k_dim_i;
                    m_d     = m_dim_i;
                    tgt_d   = target_i;
                end
            end
            LOAD: begin
                start_err_d = start_i;
                if (cnt_q == ne_q + ke_q + CW'(2)) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
            end
            COMPUTE: begin
                start_err_d = start_i;
                if (cnt_q == ne_q + ke_q + me_q) begin
                    state_d = WRITEBACK;
                    cnt_d   = '0;
                end
            end
            WRITEBACK: begin
                start_err_d = start_i;
                if (cnt_q == ne_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                start_err_d = start_i;
                state_d     = IDLE;
                cnt_d       = '0;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered and aligned.
        ne_d        = CW'(n_d);
        ke_d        = CW'(k_d);
        busy_d      = (state_d != IDLE);
        rd_en_d     = (state_d == LOAD) && (cnt_d <= ne_d + ke_d + CW'(1));
        rd_sel_d    = rd_en_d && (cnt_d > ne_d);
        rd_row_d    = '0;
        if (rd_en_d) begin
            rd_row_d = rd_sel_d ? IDXW'(cnt_d - ne_d - CW'(1)) : IDXW'(cnt_d);
        end
        load_a_d    = rd_en_q & ~rd_sel_q;
        load_b_d    = rd_en_q & rd_sel_q;
        pe_clr_d    = (state_d == LOAD) && (cnt_d == '0);
        pe_en_d     = (state_d == COMPUTE);
        wr_en_d     = (state_d == WRITEBACK);
        wr_row_d    = wr_en_d ? IDXW'(cnt_d) : '0;
        wr_target_d = wr_en_d ? tgt_d : '0;
        done_d      = (state_d == DONE);
        flags_d     = accept ? '0 : (flags_q | flag_set);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            tgt_q       <= '0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_row_q    <= '0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            pe_clr_q    <= 1'b0;
            pe_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_target_q <= '0;
            wr_row_q    <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            k_q         <= k_d;
            m_q         <= m_d;
            tgt_q       <= tgt_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            rd_sel_q    <= rd_sel_d;
            rd_row_q    <= rd_row_d;
            load_a_q    <= load_a_d;
            load_b_q    <= load_b_d;
            pe_clr_q    <= pe_clr_d;
            pe_en_q     <= pe_en_d;
            wr_en_q     <= wr_en_d;
            wr_target_q <= wr_target_d;
            wr_row_q    <= wr_row_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
        end
    end

    assign busy_o      = busy_q;
    assign rd_en_o     = rd_en_q;
    assign rd_sel_o    = rd_sel_q;
    assign rd_row_o    = rd_row_q;
    assign load_a_o    = load_a_q;
    assign load_b_o    = load_b_q;
    assign pe_clr_o    = pe_clr_q;
    assign pe_en_o     = pe_en_q;
    assign wr_en_o     = wr_en_q;
    assign wr_target_o = wr_target_q;
    assign wr_row_o    = wr_row_q;
    assign flags_o     = flags_q;
    assign done_o      = done_q;
    assign start_err_o = start_err_q;

endmodule
